id_decode_stage: RTL and testbench

// Registered decode stage between fetch and execute. Accepts one 32-bit RV32I(+optional RV32B subset) instruction
// per valid/ready handshake, and decodes it into ALU op, PC op, operand/immediate selects, expanded immediates and

---
 rtl/id_decode_stage.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_id_decode_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_stage.sv
// RV32I (+ optional RV32B logic/min/max subset) decode stage with a single registered output bundle.
// Full-throughput valid/ready handshake; flush discards both the held bundle and the incoming instruction.
module id_decode_stage #(
    parameter bit          RV32B       = 1'b0,
    parameter logic [31:0] BOOT_OFFSET = 32'h8000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_instr_i,
    input  logic [31:0] in_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [4:0]  out_alu_op_o,
    output logic [1:0]  out_pc_op_o,
    output logic [1:0]  out_op_a_sel_o,
    output logic        out_op_b_sel_o,
    output logic [2:0]  out_imm_b_sel_o,
    output logic [31:0] out_imm_o,
    output logic [31:0] out_pc_imm_o,
    output logic [4:0]  out_rs1_o,
    output logic [4:0]  out_rs2_o,
    output logic [4:0]  out_rd_o,
    output logic        out_rf_we_o,
    output logic        out_load_o,
    output logic        out_store_o,
    output logic [2:0]  out_mem_size_o,
    output logic        out_illegal_o
);

    localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB  = 5'd1,  ALU_XOR  = 5'd2,  ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_AND = 5'd4,  ALU_SRA  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_LT  = 5'd8,  ALU_LTU  = 5'd9,  ALU_GE   = 5'd10, ALU_GEU  = 5'd11;
    localparam logic [4:0] ALU_EQ  = 5'd12, ALU_NE   = 5'd13, ALU_XNOR = 5'd14, ALU_ORN  = 5'd15;
    localparam logic [4:0] ALU_ANDN = 5'd16, ALU_MIN = 5'd17, ALU_MINU = 5'd18, ALU_MAX  = 5'd19;
    localparam logic [4:0] ALU_MAXU = 5'd20;

    localparam logic [1:0] PC_JAL = 2'd0, PC_JALR = 2'd1, PC_BRANCH = 2'd2, PC_NONE = 2'd3;
    localparam logic [1:0] OPA_REG = 2'd0, OPA_CURRPC = 2'd2;
    localparam logic       OPB_REG = 1'b0, OPB_IMM = 1'b1;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4, IMM_O = 3'd5, IMM_N = 3'd6;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011, OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011, OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011, OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111, OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111, OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  alu_op;
        logic [1:0]  pc_op;
        logic [1:0]  op_a_sel;
        logic        op_b_sel;
        logic [2:0]  imm_b_sel;
        logic [31:0] imm;
        logic [31:0] pc_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rf_we;
        logic        load;
        logic        store;
        logic [2:0]  mem_size;
        logic        illegal;
    } bundle_t;

    localparam bundle_t BUNDLE_RST = '{pc_op: PC_NONE, default: '0};

    bundle_t     bundle_q, bundle_d, dec;
    logic        valid_q, valid_d;
    logic        load_en;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr_i[6:0];
    assign funct3 = in_instr_i[14:12];
    assign funct7 = in_instr_i[31:25];
    assign imm_i  = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
    assign imm_s  = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
    assign imm_b  = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7], in_instr_i[30:25],
                     in_instr_i[11:8], 1'b0};
    assign imm_u  = {in_instr_i[31:12], 12'b0};
    assign imm_j  = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12], in_instr_i[20],
                     in_instr_i[30:21], 1'b0};

    always_comb begin
        dec           = BUNDLE_RST;
        dec.pc        = in_pc_i;
        dec.alu_op    = ALU_ADD;
        dec.op_a_sel  = OPA_REG;
        dec.op_b_sel  = OPB_REG;
        dec.imm_b_sel = IMM_I;
        dec.rs1       = in_instr_i[19:15];
        dec.rs2       = in_instr_i[24:20];
        dec.rd        = in_instr_i[11:7];
        dec.mem_size  = funct3;

        if (in_instr_i[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    dec.rf_we = 1'b1;
                    case (funct7)
                        7'h00: begin
                            case (funct3)
                                3'd0: dec.alu_op = ALU_ADD;
                                3'd1: dec.alu_op = ALU_SLL;
                                3'd2: dec.alu_op = ALU_LT;
                                3'd3: dec.alu_op = ALU_LTU;
                                3'd4: dec.alu_op = ALU_XOR;
                                3'd5: dec.alu_op = ALU_SRL;
                                3'd6: dec.alu_op = ALU_OR;
                                default: dec.alu_op = ALU_AND;
                            endcase
                        end
                        7'h20: begin
                            case (funct3)
                                3'd0: dec.alu_op = ALU_SUB;
                                3'd5: dec.alu_op = ALU_SRA;
                                3'd4: begin dec.alu_op = ALU_XNOR; dec.illegal = !RV32B; end
                                3'd6: begin dec.alu_op = ALU_ORN;  dec.illegal = !RV32B; end
                                3'd7: begin dec.alu_op = ALU_ANDN; dec.illegal = !RV32B; end
                                default: dec.illegal = 1'b1;
                            endcase
                        end
                        // RV32B min/max share funct7 0x05 with the M-extension-free space.
                        7'h05: begin
                            dec.illegal = !RV32B;
                            case (funct3)
                                3'd4: dec.alu_op = ALU_MIN;
                                3'd5: dec.alu_op = ALU_MINU;
                                3'd6: dec.alu_op = ALU_MAX;
                                3'd7: dec.alu_op = ALU_MAXU;
                                default: dec.illegal = 1'b1;
                            endcase
                        end
                        default: dec.illegal = 1'b1;
                    endcase
                end
                OPC_OP_IMM: begin
                    dec.rf_we    = 1'b1;
                    dec.op_b_sel = OPB_IMM;
                    case (funct3)
                        3'd0: dec.alu_op = ALU_ADD;
                        3'd1: begin dec.alu_op = ALU_SLL; dec.illegal = (funct7 != 7'h00); end
                        3'd2: dec.alu_op = ALU_LT;
                        3'd3: dec.alu_op = ALU_LTU;
                        3'd4: dec.alu_op = ALU_XOR;
                        3'd5: begin
                            if (funct7 == 7'h00)      dec.alu_op = ALU_SRL;
                            else if (funct7 == 7'h20) dec.alu_op = ALU_SRA;
                            else                      dec.illegal = 1'b1;
                        end
                        3'd6: dec.alu_op = ALU_OR;
                        default: dec.alu_op = ALU_AND;
                    endcase
                end
                OPC_LUI: begin
                    dec.rf_we     = 1'b1;
                    dec.rs1       = '0;
                    dec.op_b_sel  = OPB_IMM;
                    dec.imm_b_sel = IMM_U;
                end
                OPC_AUIPC: begin
                    dec.rf_we     = 1'b1;
                    dec.op_a_sel  = OPA_CURRPC;
                    dec.op_b_sel  = OPB_IMM;
                    dec.imm_b_sel = IMM_U;
                end
                OPC_JAL: begin
                    dec.rf_we     = 1'b1;
                    dec.op_a_sel  = OPA_CURRPC;
                    dec.op_b_sel  = OPB_IMM;
                    dec.imm_b_sel = IMM_N;
                    dec.pc_op     = PC_JAL;
                    dec.pc_imm    = imm_j;
                end
                OPC_JALR: begin
                    dec.rf_we     = 1'b1;
                    dec.op_a_sel  = OPA_CURRPC;
                    dec.op_b_sel  = OPB_IMM;
                    dec.imm_b_sel = IMM_N;
                    dec.pc_op     = PC_JALR;
                    dec.pc_imm    = imm_i;
                    dec.illegal   = (funct3 != 3'd0);
                end
                OPC_BRANCH: begin
                    dec.pc_op  = PC_BRANCH;
                    dec.pc_imm = imm_b;
                    case (funct3)
                        3'd0: dec.alu_op = ALU_EQ;
                        3'd1: dec.alu_op = ALU_NE;
                        3'd4: dec.alu_op = ALU_LT;
                        3'd5: dec.alu_op = ALU_GE;
                        3'd6: dec.alu_op = ALU_LTU;
                        3'd7: dec.alu_op = ALU_GEU;
                        default: dec.illegal = 1'b1;
                    endcase
                end
                OPC_LOAD: begin
                    dec.rf_we    = 1'b1;
                    dec.load     = 1'b1;
                    dec.op_b_sel = OPB_IMM;
                    dec.illegal  = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
                end
                OPC_STORE: begin
                    dec.store     = 1'b1;
                    dec.op_b_sel  = OPB_IMM;
                    dec.imm_b_sel = IMM_S;
                    dec.illegal   = (funct3 > 3'd2);
                end
                OPC_MISC_MEM: ;
                OPC_SYSTEM: dec.illegal = (funct3 != 3'd0);
                default: dec.illegal = 1'b1;
            endcase
        end

        if (dec.illegal) begin
            dec.rf_we = 1'b0;
            dec.load  = 1'b0;
            dec.store = 1'b0;
            dec.pc_op = PC_NONE;
        end
        if (dec.rd == 5'd0) begin
            dec.rf_we = 1'b0;
        end

        case (dec.imm_b_sel)
            IMM_I:   dec.imm = imm_i;
            IMM_S:   dec.imm = imm_s;
            IMM_B:   dec.imm = imm_b;
            IMM_U:   dec.imm = imm_u;
            IMM_J:   dec.imm = imm_j;
            IMM_O:   dec.imm = BOOT_OFFSET;
            IMM_N:   dec.imm = 32'd4;
            default: dec.imm = '0;
        endcase
    end

    assign in_ready_o = !valid_q || out_ready_i;
    assign load_en    = in_valid_i && in_ready_o && !flush_i;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_en) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            bundle_q <= BUNDLE_RST;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid_o     = valid_q;
    assign out_pc_o        = bundle_q.pc;
    assign out_alu_op_o    = bundle_q.alu_op;
    assign out_pc_op_o     = bundle_q.pc_op;
    assign out_op_a_sel_o  = bundle_q.op_a_sel;
    assign out_op_b_sel_o  = bundle_q.op_b_sel;
    assign out_imm_b_sel_o = bundle_q.imm_b_sel;
    assign out_imm_o       = bundle_q.imm;
    assign out_pc_imm_o    = bundle_q.pc_imm;
    assign out_rs1_o       = bundle_q.rs1;
    assign out_rs2_o       = bundle_q.rs2;
    assign out_rd_o        = bundle_q.rd;
    assign out_rf_we_o     = bundle_q.rf_we;
    assign out_load_o      = bundle_q.load;
    assign out_store_o     = bundle_q.store;
    assign out_mem_size_o  = bundle_q.mem_size;
    assign out_illegal_o   = bundle_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed-vector bench for id_decode_stage: one instance without and one with the RV32B subset,
// both fed identical stimulus.
module tb_id_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  alu;
        logic [1:0]  pc_op;
        logic [1:0]  op_a;
        logic        op_b;
        logic [2:0]  isel;
        logic [31:0] imm;
        logic [31:0] pc_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        st;
        logic [2:0]  msz;
        logic        ill;
    } bund_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        bund_t       exp;
        bit          bop;
        bit          partial;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b1;

    logic        rdy_a, vld_a, rdy_b, vld_b;
    logic [31:0] pc_a, imm_a, pcimm_a, pc_b, imm_b, pcimm_b;
    logic [4:0]  alu_a, rs1_a, rs2_a, rd_a, alu_b, rs1_b, rs2_b, rd_b;
    logic [1:0]  pcop_a, opa_a, pcop_b, opa_b;
    logic        opb_a, we_a, ld_a, st_a, ill_a, opb_b, we_b, ld_b, st_b, ill_b;
    logic [2:0]  isel_a, msz_a, isel_b, msz_b;
    bund_t       obs_a, obs_b;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    id_decode_stage #(.RV32B(1'b0), .BOOT_OFFSET(32'h8000)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy_a),
        .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(vld_a), .out_ready_i(out_ready),
        .out_pc_o(pc_a), .out_alu_op_o(alu_a), .out_pc_op_o(pcop_a), .out_op_a_sel_o(opa_a),
        .out_op_b_sel_o(opb_a), .out_imm_b_sel_o(isel_a), .out_imm_o(imm_a), .out_pc_imm_o(pcimm_a),
        .out_rs1_o(rs1_a), .out_rs2_o(rs2_a), .out_rd_o(rd_a), .out_rf_we_o(we_a),
        .out_load_o(ld_a), .out_store_o(st_a), .out_mem_size_o(msz_a), .out_illegal_o(ill_a)
    );

    id_decode_stage #(.RV32B(1'b1), .BOOT_OFFSET(32'h8000)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy_b),
        .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(vld_b), .out_ready_i(out_ready),
        .out_pc_o(pc_b), .out_alu_op_o(alu_b), .out_pc_op_o(pcop_b), .out_op_a_sel_o(opa_b),
        .out_op_b_sel_o(opb_b), .out_imm_b_sel_o(isel_b), .out_imm_o(imm_b), .out_pc_imm_o(pcimm_b),
        .out_rs1_o(rs1_b), .out_rs2_o(rs2_b), .out_rd_o(rd_b), .out_rf_we_o(we_b),
        .out_load_o(ld_b), .out_store_o(st_b), .out_mem_size_o(msz_b), .out_illegal_o(ill_b)
    );

    assign obs_a = {pc_a, alu_a, pcop_a, opa_a, opb_a, isel_a, imm_a, pcimm_a,
                    rs1_a, rs2_a, rd_a, we_a, ld_a, st_a, msz_a, ill_a};
    assign obs_b = {pc_b, alu_b, pcop_b, opa_b, opb_b, isel_b, imm_b, pcimm_b,
                    rs1_b, rs2_b, rd_b, we_b, ld_b, st_b, msz_b, ill_b};

    function automatic bund_t mk(logic [31:0] pc, logic [4:0] alu, logic [1:0] pc_op, logic [1:0] op_a,
                                 logic op_b, logic [2:0] isel, logic [31:0] imm, logic [31:0] pc_imm,
                                 logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic we,
                                 logic ld, logic st, logic [2:0] msz, logic ill);
        return {pc, alu, pc_op, op_a, op_b, isel, imm, pc_imm, rs1, rs2, rd, we, ld, st, msz, ill};
    endfunction

    function automatic bund_t illegal_exp(logic [31:0] pc);
        return mk(pc, 5'd0, 2'd3, 2'd0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    endfunction

    task automatic add_vec(string name, logic [31:0] instr, bund_t exp, bit bop, bit partial);
        vec_t v;
        v.name = name; v.instr = instr; v.exp = exp; v.bop = bop; v.partial = partial;
        vecs.push_back(v);
    endtask

    // partial compares only the fields an illegal instruction pins down
    task automatic check_bund(string name, bund_t act, bund_t exp, bit partial);
        bit ok;
        checks++;
        if (partial)
            ok = (act.pc == exp.pc) && (act.pc_op == exp.pc_op) && (act.we == exp.we) &&
                 (act.ld == exp.ld) && (act.st == exp.st) && (act.ill == exp.ill);
        else
            ok = (act == exp);
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bund_t sub_exp;
        //        name       instr         pc          alu  pcop opa opb isel imm           pc_imm        rs1 rs2 rd  we ld st msz ill
        add_vec("addi",   32'h00500093, mk(32'h000, 0, 3, 0, 1, 0, 32'd5,        32'd0,        0,  5,  1,  1, 0, 0, 0, 0), 0, 0);
        add_vec("sub",    32'h402081B3, mk(32'h004, 1, 3, 0, 0, 0, 32'h402,      32'd0,        1,  2,  3,  1, 0, 0, 0, 0), 0, 0);
        add_vec("jal",    32'h008000EF, mk(32'h100, 0, 0, 2, 1, 6, 32'd4,        32'd8,        0,  8,  1,  1, 0, 0, 0, 0), 0, 0);
        add_vec("andn",   32'h4020F1B3, mk(32'h008, 16, 3, 0, 0, 0, 32'h402,     32'd0,        1,  2,  3,  1, 0, 0, 7, 0), 1, 0);
        add_vec("lui",    32'h123452B7, mk(32'h00C, 0, 3, 0, 1, 3, 32'h12345000, 32'd0,        0,  3,  5,  1, 0, 0, 5, 0), 0, 0);
        add_vec("auipc",  32'h00001117, mk(32'h200, 0, 3, 2, 1, 3, 32'h1000,     32'd0,        0,  0,  2,  1, 0, 0, 1, 0), 0, 0);
        add_vec("beq",    32'hFE208EE3, mk(32'h300, 12, 2, 0, 0, 0, 32'hFFFFFFE2, 32'hFFFFFFFC, 1,  2, 29,  0, 0, 0, 0, 0), 0, 0);
        add_vec("lw",     32'h0080A283, mk(32'h010, 0, 3, 0, 1, 0, 32'd8,        32'd0,        1,  8,  5,  1, 1, 0, 2, 0), 0, 0);
        add_vec("sw",     32'hFE20AE23, mk(32'h014, 0, 3, 0, 1, 1, 32'hFFFFFFFC, 32'd0,        1,  2, 28,  0, 0, 1, 2, 0), 0, 0);
        add_vec("jalr",   32'h00C100E7, mk(32'h018, 0, 1, 2, 1, 6, 32'd4,        32'd12,       2, 12,  1,  1, 0, 0, 0, 0), 0, 0);
        add_vec("addi_x0",32'h00100013, mk(32'h01C, 0, 3, 0, 1, 0, 32'd1,        32'd0,        0,  1,  0,  0, 0, 0, 0, 0), 0, 0);
        add_vec("srai",   32'h4030D213, mk(32'h020, 5, 3, 0, 1, 0, 32'h403,      32'd0,        1,  3,  4,  1, 0, 0, 5, 0), 0, 0);
        add_vec("slli_bad",32'h40309213, illegal_exp(32'h024), 0, 1);
        add_vec("low_bits",32'h00500090, illegal_exp(32'h028), 0, 1);
        add_vec("ecall",  32'h00000073, mk(32'h02C, 0, 3, 0, 0, 0, 32'd0,        32'd0,        0,  0,  0,  0, 0, 0, 0, 0), 0, 0);
        add_vec("csrrw",  32'h34011073, illegal_exp(32'h030), 0, 1);
        add_vec("ld_f3",  32'h00003003, illegal_exp(32'h034), 0, 1);
        add_vec("min",    32'h0A20C1B3, mk(32'h038, 17, 3, 0, 0, 0, 32'hA2,      32'd0,        1,  2,  3,  1, 0, 0, 4, 0), 1, 0);
        add_vec("slt",    32'h0020A1B3, mk(32'h03C, 8, 3, 0, 0, 0, 32'd2,        32'd0,        1,  2,  3,  1, 0, 0, 2, 0), 0, 0);
        sub_exp = vecs[1].exp;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_valid", vld_a, 1'b0);
        check_bit("rst_ready", rdy_a, 1'b1);
        check_bund("rst_bundle", obs_a, mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        rst = 1'b0;

        // table vectors, one per handshake with execute always ready
        foreach (vecs[i]) begin
            in_instr = vecs[i].instr;
            in_pc    = vecs[i].exp.pc;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check_bit({vecs[i].name, "_valid"}, vld_a, 1'b1);
            if (vecs[i].bop)
                check_bund({vecs[i].name, "_norv32b"}, obs_a, illegal_exp(vecs[i].exp.pc), 1);
            else
                check_bund({vecs[i].name, "_a"}, obs_a, vecs[i].exp, vecs[i].partial);
            check_bund({vecs[i].name, "_b"}, obs_b, vecs[i].exp, vecs[i].partial);
            $display("vec %s instr=%h pc=%h", vecs[i].name, vecs[i].instr, vecs[i].exp.pc);
        end
        @(negedge clk);
        check_bit("drain_valid", vld_a, 1'b0);

        // backpressure: held bundle stays stable, a competing input is not taken
        out_ready = 1'b0;
        in_instr = vecs[1].instr; in_pc = sub_exp.pc; in_valid = 1'b1;
        @(negedge clk);
        check_bit("hold_load_valid", vld_a, 1'b1);
        check_bit("hold_ready_low", rdy_a, 1'b0);
        in_instr = 32'h00500093; in_pc = 32'h500;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_bit("hold_valid", vld_a, 1'b1);
            check_bund("hold_bundle", obs_a, sub_exp, 0);
            $display("hold cycle %0d pc=%h alu=%0d", c, pc_a, alu_a);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check_bit("hold_drained", vld_a, 1'b0);

        // back-to-back stream: addi xk,x0,k for k=1..8
        for (int k = 1; k <= 8; k++) begin
            in_instr = {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
            in_pc    = 32'h1000 + 32'(4 * k);
            in_valid = 1'b1;
            check_bit("stream_ready", rdy_a, 1'b1);
            @(negedge clk);
            check_bit("stream_valid", vld_a, 1'b1);
            check_val("stream_imm", imm_a, 32'(k));
            check_val("stream_pc", pc_a, 32'h1000 + 32'(4 * k));
            $display("stream k=%0d rd=%0d imm=%0d", k, rd_a, imm_a);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_bit("stream_end", vld_a, 1'b0);

        // flush with a held bundle and a new input in the same cycle
        out_ready = 1'b0;
        in_instr = 32'h00500093; in_pc = 32'h600; in_valid = 1'b1;
        @(negedge clk);
        check_bit("flush_pre", vld_a, 1'b1);
        flush = 1'b1; out_ready = 1'b1;
        in_instr = 32'h008000EF; in_pc = 32'h700;
        @(negedge clk);
        check_bit("flush_valid", vld_a, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_bit("flush_discard", vld_a, 1'b0);
        check_val("flush_pc_kept", pc_a, 32'h600);
        $display("flush done valid=%0b", vld_a);

        // asynchronous reset in the middle of a stream
        in_instr = 32'h008000EF; in_pc = 32'h800; in_valid = 1'b1;
        @(negedge clk);
        check_bit("prerst_valid", vld_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_bit("arst_valid", vld_a, 1'b0);
        check_bund("arst_bundle", obs_a, mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        check_bit("arst_ready", rdy_a, 1'b1);
        $display("async reset pc=%h pc_op=%0d", pc_a, pcop_a);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
